// File: rtl/irq_ctrl_pkg.sv
// rtl/irq_ctrl_pkg.sv - shared constants for the interrupt controller
package irq_ctrl_pkg;

  localparam int IRQ_N_SRC = 6;

  localparam logic [1:0] IRQ_MASK = 2'd0;
  localparam logic [1:0] IRQ_MODE = 2'd1;
  localparam logic [1:0] IRQ_PEND = 2'd2;
  localparam logic [1:0] IRQ_RAW  = 2'd3;

  localparam int IRQ_TC0 = 0;
  localparam int IRQ_TC1 = 1;
  localparam int IRQ_EXT = 2;

endpackage

// File: rtl/irq_sync_edge.sv
// rtl/irq_sync_edge.sv - two-flop synchroniser plus a history flop for rising-edge detection
module irq_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic sync_o,
  output logic rise_o
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign sync_o = s2_q;
  assign rise_o = s2_q & ~s3_q;

endmodule

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - interrupt controller: per-source sync, edge/level pending, mask, word register port
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int N_SRC = IRQ_N_SRC
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] src,
  input  logic [31:2]      Addr,
  input  logic             WE,
  input  logic [31:0]      Din,
  output logic [31:0]      Dout,
  output logic [N_SRC-1:0] HWInt
);

  logic [N_SRC-1:0] raw, rise;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] mode_q, mode_d;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] w1c;
  logic             unused_ok;

  for (genvar i = 0; i < N_SRC; i++) begin : g_sync
    irq_sync_edge u_sync (
      .clk    (clk),
      .reset  (reset),
      .d_i    (src[i]),
      .sync_o (raw[i]),
      .rise_o (rise[i])
    );
  end

  always_comb begin
    mask_d = mask_q;
    mode_d = mode_q;
    w1c    = '0;
    if (WE) begin
      case (Addr[3:2])
        IRQ_MASK: mask_d = Din[N_SRC-1:0];
        IRQ_MODE: mode_d = Din[N_SRC-1:0];
        IRQ_PEND: w1c    = Din[N_SRC-1:0];
        default:  ;
      endcase
    end
    // Edge bits: a fresh rise overrides a simultaneous clear. Level bits track the synced input.
    pend_d = (mode_q & (rise | (pend_q & ~w1c))) | (~mode_q & raw);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask_q <= '0;
      mode_q <= '0;
      pend_q <= '0;
    end else begin
      mask_q <= mask_d;
      mode_q <= mode_d;
      pend_q <= pend_d;
    end
  end

  always_comb begin
    Dout = '0;
    case (Addr[3:2])
      IRQ_MASK: Dout[N_SRC-1:0] = mask_q;
      IRQ_MODE: Dout[N_SRC-1:0] = mode_q;
      IRQ_PEND: Dout[N_SRC-1:0] = pend_q;
      default:  Dout[N_SRC-1:0] = raw;
    endcase
  end

  assign HWInt     = pend_q & mask_q;
  assign unused_ok = ^{Addr[31:4], Din};

endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - self-checking bench for irq_ctrl: vector table, directed corner cases, random vs model
module tb_irq_ctrl;
  import irq_ctrl_pkg::*;

  logic        clk;
  logic        reset;
  logic [5:0]  src;
  logic [31:2] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic [5:0]  HWInt;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: registers plus the last three per-edge samples of src, newest first.
  logic [5:0] m_mask, m_mode, m_pend;
  logic [5:0] hist [3];

  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [31:0] din;
    logic [5:0]  exp_hw;
    logic [31:0] exp_dout;
  } vec_t;

  vec_t vecs [9];

  irq_ctrl #(.N_SRC(6)) dut (
    .clk   (clk),
    .reset (reset),
    .src   (src),
    .Addr  (Addr),
    .WE    (WE),
    .Din   (Din),
    .Dout  (Dout),
    .HWInt (HWInt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return {26'h0, m_mask};
      2'd1:    return {26'h0, m_mode};
      2'd2:    return {26'h0, m_pend};
      default: return {26'h0, hist[1]};
    endcase
  endfunction

  task automatic model_reset();
    m_mask = '0;
    m_mode = '0;
    m_pend = '0;
    for (int i = 0; i < 3; i++) hist[i] = '0;
  endtask

  // One clock edge: advance the model with the inputs held at the edge, then compare.
  task automatic step();
    logic [5:0] lvl, rise_v, clr;
    @(posedge clk);
    lvl    = hist[1];
    rise_v = hist[1] & ~hist[2];
    clr    = (WE && Addr[3:2] == 2'd2) ? Din[5:0] : 6'h0;
    for (int i = 0; i < 6; i++) begin
      if (m_mode[i]) m_pend[i] = rise_v[i] | (m_pend[i] & ~clr[i]);
      else           m_pend[i] = lvl[i];
    end
    if (WE && Addr[3:2] == 2'd0) m_mask = Din[5:0];
    if (WE && Addr[3:2] == 2'd1) m_mode = Din[5:0];
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = src;
    #1;
    check("model_hwint", {26'h0, HWInt}, {26'h0, m_pend & m_mask});
    check("model_dout", Dout, m_read(Addr[3:2]));
  endtask

  task automatic set_bus(input logic we, input logic [1:0] a, input logic [31:0] d);
    WE   = we;
    Addr = {28'h0, a};
    Din  = d;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    set_bus(1'b1, a, d);
    step();
    WE = 1'b0;
  endtask

  task automatic idle(input int n);
    WE = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reset = 1'b0;
    src   = '0;
    set_bus(1'b0, 2'd0, 32'h0);
    model_reset();

    vecs[0] = '{1'b1, 2'd0, 32'h0000_003F, 6'h00, 32'h0000_003F};
    vecs[1] = '{1'b1, 2'd1, 32'h0000_002A, 6'h00, 32'h0000_002A};
    vecs[2] = '{1'b0, 2'd0, 32'h0000_0000, 6'h00, 32'h0000_003F};
    vecs[3] = '{1'b1, 2'd3, 32'hFFFF_FFFF, 6'h00, 32'h0000_0000};
    vecs[4] = '{1'b1, 2'd0, 32'hFFFF_FFC5, 6'h00, 32'h0000_0005};
    vecs[5] = '{1'b0, 2'd1, 32'h0000_0000, 6'h00, 32'h0000_002A};
    vecs[6] = '{1'b1, 2'd2, 32'h0000_003F, 6'h00, 32'h0000_0000};
    vecs[7] = '{1'b1, 2'd1, 32'h0000_0000, 6'h00, 32'h0000_0000};
    vecs[8] = '{1'b0, 2'd0, 32'h0000_0000, 6'h00, 32'h0000_0005};

    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    model_reset();

    // Register access table
    for (int v = 0; v < 9; v++) begin
      set_bus(vecs[v].we, vecs[v].addr, vecs[v].din);
      step();
      check($sformatf("vec%0d_hwint", v), {26'h0, HWInt}, {26'h0, vecs[v].exp_hw});
      check($sformatf("vec%0d_dout", v), Dout, vecs[v].exp_dout);
    end
    WE = 1'b0;

    // Reset held with all sources high
    #2 reset = 1'b0;
    src = 6'h3F;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hwint", {26'h0, HWInt}, 32'h0);
    for (int a = 0; a < 4; a++) begin
      Addr = {28'h0, 2'(a)};
      #1 check($sformatf("rst_reg%0d", a), Dout, 32'h0);
    end
    reset = 1'b1;
    model_reset();
    wr(IRQ_MASK, 32'h3F);
    check("rel_hwint_e1", {26'h0, HWInt}, 32'h0);
    wr(IRQ_MODE, 32'h0);
    check("rel_hwint_e2", {26'h0, HWInt}, 32'h0);
    idle(1);
    check("rel_hwint_e3", {26'h0, HWInt}, 32'h3F);

    // Settle to level mode with quiet sources
    src = '0;
    wr(IRQ_MODE, 32'h0);
    idle(3);

    // Edge capture and acknowledge
    wr(IRQ_MODE, 32'h3F);
    wr(IRQ_MASK, 32'h01);
    src[IRQ_TC0] = 1'b1;
    step();
    src = '0;
    step();
    step();
    check("edge_hwint", {26'h0, HWInt}, 32'h01);
    idle(3);
    check("edge_hold", {26'h0, HWInt}, 32'h01);
    wr(IRQ_PEND, 32'h01);
    check("edge_ack", {26'h0, HWInt}, 32'h0);

    // Rise and W1C land on the same edge
    src[IRQ_TC1] = 1'b1;
    step();
    src = '0;
    step();
    wr(IRQ_PEND, 32'h02);
    check("set_wins", Dout, 32'h02);
    wr(IRQ_PEND, 32'h02);
    check("set_wins_clr", Dout, 32'h0);

    // Masked edge is still recorded
    wr(IRQ_MASK, 32'h0);
    src[IRQ_EXT] = 1'b1;
    step();
    src = '0;
    step();
    step();
    check("masked_hwint", {26'h0, HWInt}, 32'h0);
    set_bus(1'b0, IRQ_PEND, 32'h0);
    #1 check("masked_pend", Dout, 32'h04);
    wr(IRQ_MASK, 32'h04);
    check("unmask_hwint", {26'h0, HWInt}, 32'h04);
    wr(IRQ_PEND, 32'h04);

    // Level mode: five-cycle high, W1C mid-way has no effect
    wr(IRQ_MODE, 32'h0);
    wr(IRQ_MASK, 32'h02);
    for (int j = 0; j < 9; j++) begin
      src = (j < 5) ? 6'h02 : 6'h00;
      set_bus(j == 3, IRQ_PEND, 32'h02);
      step();
      check($sformatf("level_j%0d", j), {26'h0, HWInt},
            (j >= 2 && j <= 6) ? 32'h02 : 32'h0);
    end
    WE = 1'b0;

    // Asynchronous reset with interrupts pending
    wr(IRQ_MODE, 32'h3F);
    wr(IRQ_MASK, 32'h3F);
    src = 6'h05;
    step();
    src = '0;
    step();
    step();
    check("pre_async_hwint", {26'h0, HWInt}, 32'h05);
    #2 reset = 1'b0;
    #1 check("async_rst_hwint", {26'h0, HWInt}, 32'h0);
    model_reset();
    src = 6'h01;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Randomised traffic against the reference model
    for (int c = 0; c < 600; c++) begin
      src  = src ^ (6'($urandom) & 6'($urandom));
      WE   = ($urandom_range(0, 3) == 0);
      Addr = {28'($urandom), 2'($urandom)};
      Din  = $urandom;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Memory-mapped interrupt controller between the interrupt sources (`tc0_irq`, `tc1_irq`, external `interrupt`, spare lines) and the CPU's `HWInt[5:0]` input. It synchronises each source, detects edges or passes levels per source, holds sticky pending bits and applies a software mask. The Bridge reaches it through a TC-style word port (`Addr`/`WE`/`Din`/`Dout`) so the exception handler can acknowledge edge interrupts.

## Interface
- `N_SRC`, default 6: number of interrupt sources. Equals the `HWInt` width. Maximum 32.
- `clk` input 1: the single clock. All state changes on the rising edge.
- `reset` input 1: asynchronous, active-low. All registers clear while `reset`=0.
- `src` input `N_SRC`: raw interrupt requests. Bit 0 is tc0, bit 1 is tc1, bit 2 is external, the rest are spare. May be asynchronous.
- `Addr` input [31:2]: word address from the Bridge. Only `Addr[3:2]` is decoded.
- `WE` input 1: write strobe, already qualified by the Bridge's address decode.
- `Din` input 32: write data.
- `Dout` output 32: combinational read data. Unused upper bits read 0.
- `HWInt` output `N_SRC`: masked pending interrupts to the CPU.

## Operation
- Register map, selected by `Addr[3:2]`:
  - 0 MASK: read/write. Bit i=1 enables source i.
  - 1 MODE: read/write. Bit i=1 selects edge mode, 0 selects level mode.
  - 2 PENDING: read. Writing 1 to a bit clears that edge-mode bit (W1C).
  - 3 RAW: read-only synchronised source value. Writes are ignored.
- Synchroniser per source: `s1 <= src`, `s2 <= s1`. RAW returns `s2`.
- Edge detection uses a third flop: `s3 <= s2`. `rise = s2 & ~s3`.
- Edge-mode pending bit: set on `rise`. Cleared by a PENDING write with `Din[i]`=1. Otherwise holds.
- Level-mode pending bit: follows `s2` every cycle. W1C has no effect.
- Same cycle set and clear: set wins, so the bit stays 1.
- MODE change from edge to level: pending becomes `s2` on the next edge. Change from level to edge: the current pending value is kept. A held-high source does not set it again until its next rise.
- MASK does not gate pending. A masked edge is still recorded and asserts `HWInt` once it is unmasked.
- `HWInt = pending & MASK`, combinational from registers, so there is no comb path from `src`.

## Timing
- Reset values: MASK=0, MODE=0, pending=0, s1/s2/s3=0. So `HWInt`=0 and `Dout`=0 at address 0.
- Latency from a source rising before edge k (edge mode, unmasked): s1 at k, s2 at k+1, pending at k+2. `HWInt` is high after edge k+2. Level mode has the same latency.
- The minimum detectable pulse is one `clk` period high. An edge counts once, however long the level stays high.
- Writes take effect at the clock edge where `WE`=1. MASK written at edge k gates `HWInt` from k onward.
- `Dout` reflects register state after the previous edge. A read in the same cycle as a write returns the old value.
- Reset asserted mid-operation clears all pending and config bits immediately. After reset is released, a source already high produces a rise two edges later, because s3 was 0.

## Structure
- Shared package: `N_SRC` default, register offsets (`IRQ_MASK`=0, `IRQ_MODE`=1, `IRQ_PEND`=2, `IRQ_RAW`=3), and source index constants (`IRQ_TC0`, `IRQ_TC1`, `IRQ_EXT`).
- One sub-module, `irq_sync_edge`: a three-flop synchroniser with `rise` output, instantiated per source through a generate loop.
- The register file, pending logic and read mux stay in `irq_ctrl`.

## Test plan
- Reset: hold `reset`=0 with `src`=6'h3F. Required: `HWInt`=0 and every register reads 0. Release reset, write MASK=6'h3F, MODE=0. Required: `HWInt`=6'h3F two edges later.
- Edge capture: MODE=6'h3F, MASK=6'h01, one-cycle pulse on `src[0]`. Required: `HWInt`=6'h01 held after the pulse ends. Write PENDING=6'h01. Required: `HWInt`=0 on the next edge.
- Set beats clear: a `src[1]` rise reaches pending in the same cycle as a W1C of bit 1. Required: PENDING bit 1 reads 1.
- Masked recording: MASK=0, pulse `src[2]` in edge mode. Required: `HWInt`=0 and PENDING=6'h04. Write MASK=6'h04. Required: `HWInt`=6'h04.
- Level mode: MODE=0, MASK=6'h02. Drive `src[1]` high for 5 cycles. Required: `HWInt[1]` high for 5 cycles, delayed 2. A W1C of bit 1 while the source is high has no effect.
- Async reset mid-pend: pending=6'h05, pull `reset` low between edges. Required: `HWInt`=0 immediately, without waiting for a clock edge.
